// File: rtl/tpg_pkg.sv
// Shared types and constants for the test pattern generator scheduler.
// Mode codes follow the pattern mux encoding.
package tpg_pkg;

    localparam int unsigned TPG_MODE_W  = 5;
    localparam int unsigned TPG_DWELL_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DWELL
    } tpg_state_e;

    typedef struct packed {
        logic [TPG_MODE_W-1:0]  mode;
        logic [TPG_DWELL_W-1:0] dwell;
    } tpg_entry_t;

    localparam logic [TPG_MODE_W-1:0] MODE_GRAD     = 5'b01000;
    localparam logic [TPG_MODE_W-1:0] MODE_IMAGE    = 5'b00100;
    localparam logic [TPG_MODE_W-1:0] MODE_OFFSET   = 5'b00010;
    localparam logic [TPG_MODE_W-1:0] MODE_STNDRT   = 5'b00001;
    localparam logic [TPG_MODE_W-1:0] MODE_ONECOLOR = 5'b00000;

endpackage

// File: rtl/tpg_sched_table.sv
// Pattern list register file: one synchronous write port, one combinational
// read port, every entry resets to mode 0 / dwell 1.
module tpg_sched_table
    import tpg_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned MODE_W  = TPG_MODE_W,
    parameter int unsigned DWELL_W = TPG_DWELL_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_i,
    input  logic [$clog2(ENTRIES)-1:0]   wr_addr_i,
    input  logic [MODE_W+DWELL_W-1:0]    wr_data_i,
    input  logic [$clog2(ENTRIES)-1:0]   rd_addr_i,
    output logic [MODE_W+DWELL_W-1:0]    rd_data_o
);

    localparam int unsigned EW = MODE_W + DWELL_W;
    localparam logic [EW-1:0] RST_ENTRY = EW'(1);

    logic [EW-1:0] mem [ENTRIES];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem[i] <= RST_ENTRY;
            end
        end else if (wr_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem[rd_addr_i];

endmodule

// File: rtl/tpg_pattern_scheduler.sv
// Frame-synchronous pattern list sequencer feeding the pattern mux over a
// req/ack handshake; mode and dwell are latched whenever an entry is loaded.
module tpg_pattern_scheduler
    import tpg_pkg::*;
#(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned MODE_W  = TPG_MODE_W,
    parameter int unsigned DWELL_W = TPG_DWELL_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_wr_i,
    input  logic [$clog2(ENTRIES)-1:0]   cfg_addr_i,
    input  logic [MODE_W+DWELL_W-1:0]    cfg_data_i,
    input  logic [$clog2(ENTRIES):0]     cfg_len_i,
    input  logic                         run_i,
    input  logic                         sof_i,
    input  logic                         ack_i,
    output logic                         req_o,
    output logic [MODE_W-1:0]            mode_o,
    output logic                         busy_o,
    output logic [$clog2(ENTRIES)-1:0]   index_o,
    output logic [DWELL_W-1:0]           frame_cnt_o
);

    localparam int unsigned AW = $clog2(ENTRIES);
    localparam int unsigned LW = AW + 1;

    tpg_state_e                state;
    logic [LW-1:0]             len_q;
    logic [DWELL_W-1:0]        dwell_q;
    logic [AW-1:0]             nxt_idx;
    logic [AW-1:0]             rd_addr;
    logic [MODE_W+DWELL_W-1:0] rd_data;
    logic [MODE_W-1:0]         rd_mode;
    logic [DWELL_W-1:0]        rd_dwell;
    logic [DWELL_W-1:0]        dwell_eff;
    logic [LW-1:0]             len_clamped;
    logic                      last_frame;

    tpg_sched_table #(
        .ENTRIES (ENTRIES),
        .MODE_W  (MODE_W),
        .DWELL_W (DWELL_W)
    ) u_table (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_i      (cfg_wr_i),
        .wr_addr_i (cfg_addr_i),
        .wr_data_i (cfg_data_i),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign rd_mode  = rd_data[DWELL_W +: MODE_W];
    assign rd_dwell = rd_data[DWELL_W-1:0];

    // The read port always points at the entry the next load will take.
    always_comb begin
        nxt_idx     = (({1'b0, index_o} + LW'(1)) == len_q) ? '0 : index_o + AW'(1);
        rd_addr     = (state == IDLE) ? '0 : nxt_idx;
        len_clamped = (cfg_len_i > LW'(ENTRIES)) ? LW'(ENTRIES) : cfg_len_i;
        dwell_eff   = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
        last_frame  = (({1'b0, frame_cnt_o} + (DWELL_W+1)'(1)) == {1'b0, dwell_eff});
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            len_q       <= '0;
            dwell_q     <= DWELL_W'(1);
            index_o     <= '0;
            frame_cnt_o <= '0;
            mode_o      <= MODE_W'(MODE_ONECOLOR);
            req_o       <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_i && (cfg_len_i != '0)) begin
                        len_q       <= len_clamped;
                        index_o     <= '0;
                        mode_o      <= rd_mode;
                        dwell_q     <= rd_dwell;
                        frame_cnt_o <= '0;
                        req_o       <= 1'b1;
                        busy_o      <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (ack_i) begin
                        req_o       <= 1'b0;
                        frame_cnt_o <= '0;
                        if (run_i) begin
                            state <= DWELL;
                        end else begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                DWELL: begin
                    // Stopping wins over a coincident frame boundary.
                    if (!run_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (sof_i) begin
                        if (last_frame) begin
                            index_o     <= nxt_idx;
                            mode_o      <= rd_mode;
                            dwell_q     <= rd_dwell;
                            frame_cnt_o <= '0;
                            req_o       <= 1'b1;
                            state       <= REQ;
                        end else begin
                            frame_cnt_o <= frame_cnt_o + DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    req_o  <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
